cdb_arbiter: RTL and testbench

Common-data-bus (CDB) arbiter for the Tomasulo core. Functional units completing an operation each raise a result request (ROB tag + value). One winner per cycle is granted, and its result is broadcast on the registered CDB to the ROB and all reservation stations for wake-up. It is the only driver of the CDB and sits between the functional-unit outputs and the ROB/reservation-station write ports.

---
 rtl/tomasulo_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 63 ++++++
 rtl/cdb_arbiter.sv | 85 ++++++++
 tb/tb_cdb_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: default bus widths, CDB broadcast record
// and functional-unit opcodes.
package tomasulo_pkg;

  localparam int TAG_W_DEF  = 2;
  localparam int DATA_W_DEF = 8;
  localparam int SRC_W_DEF  = 2;

  typedef struct packed {
    logic                  valid;
    logic [TAG_W_DEF-1:0]  tag;
    logic [DATA_W_DEF-1:0] data;
    logic [SRC_W_DEF-1:0]  src;
  } cdb_bus_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_MUL = 3'd4,
    OP_LD  = 3'd5
  } fu_op_e;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot requester arbiter. Rotating-pointer round-robin when
// CDB_ROUND_ROBIN_EN is defined, otherwise fixed lowest-index priority.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
`ifdef CDB_ROUND_ROBIN_EN
  input  logic                         clk,
  input  logic                         rst,
`endif
  input  logic [NUM_REQ-1:0]           req,
  input  logic                         en,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [$clog2(NUM_REQ)-1:0]   gnt_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic             found;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

`ifdef CDB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
`endif

  // NOTE: every signal gets a default before the search loop so no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef CDB_ROUND_ROBIN_EN
      sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
`else
      sum = (IDX_W+1)'(k);
`endif
      idx = sum[IDX_W-1:0];
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

`ifdef CDB_ROUND_ROBIN_EN
  // Pointer moves just past the winner; idle or suppressed cycles leave it alone.
  always_comb begin
    ptr_d = ptr_q;
    if (found) ptr_d = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments to avoid simulation races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants one functional-unit result per cycle and
// broadcasts it on a registered CDB. Round-robin when CDB_ROUND_ROBIN_EN is defined.
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        cdb_hold,
  input  logic                        flush,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_data,
  output logic [$clog2(NUM_REQ)-1:0]  cdb_src
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic               grant_en;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;

  logic               valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [IDX_W-1:0]   src_q, src_d;

  // Flush, hold and reset all suppress the grant; the pointer only sees real grants.
  assign grant_en = ~(cdb_hold | flush | rst);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
`ifdef CDB_ROUND_ROBIN_EN
    .clk     (clk),
    .rst     (rst),
`endif
    .req     (req_valid),
    .en      (grant_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;

  // Payload keeps its last value when nothing transfers.
  always_comb begin
    valid_d = |gnt;
    tag_d   = tag_q;
    data_d  = data_q;
    src_d   = src_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        tag_d  = req_tag[i*TAG_W +: TAG_W];
        data_d = req_data[i*DATA_W +: DATA_W];
      end
    end
    if (valid_d) src_d = gnt_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign cdb_valid = valid_q;
  assign cdb_tag   = tag_q;
  assign cdb_data  = data_q;
  assign cdb_src   = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed steps plus a randomized phase,
// compared against a behavioural model of the grant/broadcast rules.
module tb_cdb_arbiter;

  localparam int N      = 4;
  localparam int TAG_W  = 2;
  localparam int DATA_W = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_valid;
  logic [N*TAG_W-1:0]   req_tag;
  logic [N*DATA_W-1:0]  req_data;
  logic [N-1:0]         req_ready;
  logic                 cdb_hold;
  logic                 flush;
  logic                 cdb_valid;
  logic [TAG_W-1:0]     cdb_tag;
  logic [DATA_W-1:0]    cdb_data;
  logic [1:0]           cdb_src;

  logic [TAG_W-1:0]  u_tag  [N];
  logic [DATA_W-1:0] u_data [N];

  int checks = 0;
  int errors = 0;
  int obs_pulses;

  // Reference model state
  int                m_ptr;
  logic              m_valid;
  logic [TAG_W-1:0]  m_tag;
  logic [DATA_W-1:0] m_data;
  int                m_src;

  bit pending [N];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_tag[i*TAG_W +: TAG_W]    = u_tag[i];
      req_data[i*DATA_W +: DATA_W] = u_data[i];
    end
  end

  cdb_arbiter #(.NUM_REQ(N), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_hold  (cdb_hold),
    .flush     (flush),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner by the arbitration rules, or -1 when no grant is allowed.
  function automatic int model_grant();
    if (rst || cdb_hold || flush) return -1;
`ifdef CDB_ROUND_ROBIN_EN
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
`else
    for (int i = 0; i < N; i++)
      if (req_valid[i]) return i;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_tag = '0; m_data = '0; m_src = 0;
  endtask

  task automatic check_cdb();
    check("cdb_valid", cdb_valid, m_valid);
    check("cdb_tag",   cdb_tag,   m_tag);
    check("cdb_data",  cdb_data,  m_data);
    check("cdb_src",   cdb_src,   m_src);
  endtask

  // Called 1 time unit after a rising edge with inputs already set.
  task automatic cycle(output int g);
    #1;
    g = model_grant();
    check("req_ready", req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
    @(posedge clk);
    if (rst) model_reset();
    else if (g >= 0) begin
      m_valid = 1'b1;
      m_tag   = u_tag[g];
      m_data  = u_data[g];
      m_src   = g;
      m_ptr   = (g + 1) % N;
    end else m_valid = 1'b0;
    #1;
    if (cdb_valid) obs_pulses++;
    check_cdb();
  endtask

  task automatic set_unit(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    u_tag[i] = t;
    u_data[i] = d;
  endtask

  initial begin
    int g;
    rst = 1'b1; cdb_hold = 1'b0; flush = 1'b0; req_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_unit(i, TAG_W'(i), DATA_W'(8'h10 + i));
    model_reset();
    obs_pulses = 0;

    // Reset with all requesters pending: no grant, no broadcast
    for (int c = 0; c < 3; c++) cycle(g);
    rst = 1'b0;
    cycle(g);
    check("first_grant_unit0", g, 0);

    // Single requester
    req_valid = 4'b0100; set_unit(2, 2'd2, 8'hA5);
    cycle(g);
    check("single_grant_unit2", g, 2);
    req_valid = 4'b0000;
    cycle(g);

    // All four valid for 8 cycles
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_unit(i, TAG_W'(i), DATA_W'(8'h30 + i));
    obs_pulses = 0;
    for (int c = 0; c < 8; c++) cycle(g);
    check("all_valid_pulses", obs_pulses, 8);

    // Wrap-around: grant unit 3 then 0 and 3 compete
    req_valid = 4'b1000;
    cycle(g);
    req_valid = 4'b1001;
    cycle(g);
    check("wrap_grant_unit0", g, 0);

    // Hold for two cycles, then release
    req_valid = 4'b0010; set_unit(1, 2'd1, 8'h5C); cdb_hold = 1'b1;
    cycle(g);
    cycle(g);
    cdb_hold = 1'b0;
    cycle(g);
    check("hold_release_unit1", g, 1);

    // Flush with ptr = 1 (unit 0 just granted)
    req_valid = 4'b0001;
    cycle(g);
    req_valid = 4'b0011; flush = 1'b1; cdb_hold = 1'b1;
    cycle(g);
    flush = 1'b0; cdb_hold = 1'b0;
    cycle(g);
`ifdef CDB_ROUND_ROBIN_EN
    check("post_flush_unit1", g, 1);
`else
    check("post_flush_unit0", g, 0);
`endif

    // Asynchronous reset during a live broadcast
    req_valid = 4'b0100; set_unit(2, 2'd3, 8'hE7);
    cycle(g);
    rst = 1'b1;
    #1;
    model_reset();
    check_cdb();
    req_valid = 4'b0000;
    cycle(g);
    rst = 1'b0;

    // Randomized traffic with a protocol-obeying requester model
    for (int i = 0; i < N; i++) pending[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && ($urandom_range(0, 1) == 1)) begin
          pending[i] = 1'b1;
          set_unit(i, TAG_W'($urandom), DATA_W'($urandom));
        end
        req_valid[i] = pending[i];
      end
      cdb_hold = ($urandom_range(0, 9) == 0);
      flush    = ($urandom_range(0, 14) == 0);
      cycle(g);
      if (g >= 0) pending[g] = 1'b0;
      if (flush)
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 1) == 1) pending[i] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
